// File: rtl/except_commit_pkg.sv
// rtl/except_commit_pkg.sv - excepttype field layout, raw flag indices and FSM encodings for except_commit
package except_commit_pkg;

  localparam int ET_WD  = 16;
  localparam int RAW_WD = 10;
  localparam int CNT_WD = 4;

  // packed excepttype word fields
  localparam int ET_ADDR_HI = 15;
  localparam int ET_ADDR_LO = 11;
  localparam int ET_DS      = 10;
  localparam int ET_PC_ADDR = 9;
  localparam int ET_ADES    = 8;
  localparam int ET_ADEL    = 7;
  localparam int ET_OV      = 6;
  localparam int ET_SYSCALL = 5;
  localparam int ET_BRK     = 4;
  localparam int ET_RI      = 3;
  localparam int ET_ERET    = 2;
  localparam int ET_MFC0    = 1;
  localparam int ET_MTC0    = 0;

  // raw source vector {pc_addr, ri, syscall, brk, ov, adel, ades, eret, mfc0, mtc0}
  localparam int RAW_PC_ADDR = 9;
  localparam int RAW_RI      = 8;
  localparam int RAW_SYSCALL = 7;
  localparam int RAW_BRK     = 6;
  localparam int RAW_OV      = 5;
  localparam int RAW_ADEL    = 4;
  localparam int RAW_ADES    = 3;
  localparam int RAW_ERET    = 2;
  localparam int RAW_MFC0    = 1;
  localparam int RAW_MTC0    = 0;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

endpackage

// File: rtl/except_commit_prio_enc.sv
// rtl/except_commit_prio_enc.sv - per-slot combinational exception priority encoder (module exc_prio_enc)
module exc_prio_enc
  import except_commit_pkg::*;
(
  input  logic              valid,
  input  logic              ds,
  input  logic [RAW_WD-1:0] raw,
  input  logic [4:0]        cp0_addr,
  output logic [ET_WD-1:0]  word
);

  always_comb begin
    word = '0;
    if (valid) begin
      word[ET_ADDR_HI:ET_ADDR_LO] = cp0_addr;
      word[ET_DS]                 = ds;
      if (raw[RAW_PC_ADDR])      word[ET_PC_ADDR] = 1'b1;
      else if (raw[RAW_RI])      word[ET_RI]      = 1'b1;
      else if (raw[RAW_SYSCALL]) word[ET_SYSCALL] = 1'b1;
      else if (raw[RAW_BRK])     word[ET_BRK]     = 1'b1;
      else if (raw[RAW_OV])      word[ET_OV]      = 1'b1;
      else if (raw[RAW_ADEL])    word[ET_ADEL]    = 1'b1;
      else if (raw[RAW_ADES])    word[ET_ADES]    = 1'b1;
      else begin
        // cp0 ops only reach CP0 when no exception is pending on the slot
        word[ET_ERET] = raw[RAW_ERET];
        word[ET_MFC0] = raw[RAW_MFC0];
        word[ET_MTC0] = raw[RAW_MTC0];
      end
    end
  end

endmodule

// File: rtl/except_commit.sv
// rtl/except_commit.sv - EX/MEM exception commit to CP0 with flush/redirect sequencing
// Optional exception statistics counter: EXCEPT_COMMIT_STATS_EN
module except_commit
  import except_commit_pkg::*;
#(
  parameter int EXCEPTTYPE_WD = ET_WD,
  parameter int FLUSH_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     valid_i1,
  input  logic                     valid_i2,
  input  logic [31:0]              pc_i1,
  input  logic [31:0]              pc_i2,
  input  logic                     ds_i1,
  input  logic                     ds_i2,
  input  logic [RAW_WD-1:0]        raw_i1,
  input  logic [RAW_WD-1:0]        raw_i2,
  input  logic [4:0]               cp0_addr_i1,
  input  logic [4:0]               cp0_addr_i2,
  input  logic [31:0]              bad_addr_i1,
  input  logic [31:0]              bad_addr_i2,
  input  logic [31:0]              rt_rdata_i1,
  input  logic [31:0]              rt_rdata_i2,
  output logic [EXCEPTTYPE_WD-1:0] excepttype_o1,
  output logic [EXCEPTTYPE_WD-1:0] excepttype_o2,
  output logic [31:0]              current_pc_o1,
  output logic [31:0]              current_pc_o2,
  output logic [31:0]              bad_addr_o1,
  output logic [31:0]              bad_addr_o2,
  output logic [31:0]              rt_rdata_o1,
  output logic [31:0]              rt_rdata_o2,
  input  logic                     to_be_flushed,
  input  logic [31:0]              new_pc,
  output logic                     flush_o,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  input  logic                     redirect_ready,
  output logic                     busy,
  output logic [15:0]              exc_count
);

  state_e            state, state_nxt;
  logic [CNT_WD-1:0] flush_cnt;
  logic [ET_WD-1:0]  enc1, enc2;
  logic              slot1_claims;
  logic              accept_flush;
  logic              sample;

  exc_prio_enc u_enc1 (
    .valid    (valid_i1),
    .ds       (ds_i1),
    .raw      (raw_i1),
    .cp0_addr (cp0_addr_i1),
    .word     (enc1)
  );

  exc_prio_enc u_enc2 (
    .valid    (valid_i2),
    .ds       (ds_i2),
    .raw      (raw_i2),
    .cp0_addr (cp0_addr_i2),
    .word     (enc2)
  );

  // an exception or eret in the older slot squashes whatever the younger slot carries
  assign slot1_claims = |enc1[ET_PC_ADDR:ET_ERET];
  assign accept_flush = (state == S_IDLE) && to_be_flushed;
  assign sample       = (state == S_IDLE) && !to_be_flushed && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    flush_o        = 1'b0;
    redirect_valid = 1'b0;
    busy           = 1'b0;
    case (state)
      S_IDLE: begin
        if (to_be_flushed) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        flush_o = 1'b1;
        busy    = 1'b1;
        if (flush_cnt == CNT_WD'(1)) state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        busy           = 1'b1;
        if (redirect_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (accept_flush) begin
      flush_cnt <= CNT_WD'(FLUSH_CYCLES);
    end else if (state == S_FLUSH) begin
      flush_cnt <= flush_cnt - CNT_WD'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc <= '0;
    end else if (accept_flush) begin
      redirect_pc <= new_pc;
    end
  end

  // output register: cleared on flush acceptance and frozen at 0 until back in IDLE
  always_ff @(posedge clk) begin
    if (rst || accept_flush) begin
      excepttype_o1 <= '0;
      excepttype_o2 <= '0;
      current_pc_o1 <= '0;
      current_pc_o2 <= '0;
      bad_addr_o1   <= '0;
      bad_addr_o2   <= '0;
      rt_rdata_o1   <= '0;
      rt_rdata_o2   <= '0;
    end else if (sample) begin
      excepttype_o1 <= enc1;
      current_pc_o1 <= valid_i1 ? pc_i1       : 32'h0;
      bad_addr_o1   <= valid_i1 ? bad_addr_i1 : 32'h0;
      rt_rdata_o1   <= valid_i1 ? rt_rdata_i1 : 32'h0;
      if (slot1_claims || !valid_i2) begin
        excepttype_o2 <= '0;
        current_pc_o2 <= '0;
        bad_addr_o2   <= '0;
        rt_rdata_o2   <= '0;
      end else begin
        excepttype_o2 <= enc2;
        current_pc_o2 <= pc_i2;
        bad_addr_o2   <= bad_addr_i2;
        rt_rdata_o2   <= rt_rdata_i2;
      end
    end
  end

`ifdef EXCEPT_COMMIT_STATS_EN
  logic [15:0] exc_cnt_q;
  logic        committed_exc;

  // eret sits below ET_RI, so it is excluded from the count
  assign committed_exc = (|excepttype_o1[ET_PC_ADDR:ET_RI]) || (|excepttype_o2[ET_PC_ADDR:ET_RI]);

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_cnt_q <= '0;
    end else if (accept_flush && committed_exc && (exc_cnt_q != 16'hFFFF)) begin
      exc_cnt_q <= exc_cnt_q + 16'd1;
    end
  end

  assign exc_count = exc_cnt_q;
`else
  assign exc_count = 16'h0000;
`endif

endmodule
